// File: rtl/group_gp_stage_pkg.sv
// ============================================================================
// Module : group_gp_stage_pkg
// Brief  : Shared sizing and gp-vector layout for the group G/P stage and the
//          downstream carry tree. Default operand and group widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package group_gp_stage_pkg;

    localparam int DEF_INPUTSIZE = 32;
    localparam int DEF_GROUPSIZE = 4;

    // Position of G and P inside each 2-bit group pair of the gp vector
    localparam int GP_G_IDX = 1;
    localparam int GP_P_IDX = 0;

    // Bit position of a group's G or P entry inside the packed gp vector
    function automatic int gp_pos(input int k, input int idx);
        return 2 * k + idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/group_pg.sv
// ============================================================================
// Module : group_pg
// Brief  : Combinational group lookahead: GROUPSIZE bit p/g in, group G/P out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module group_pg #(
  parameter int GROUPSIZE = 4
) (
  input  logic [GROUPSIZE-1:0] p_i,
  input  logic [GROUPSIZE-1:0] g_i,
  output logic                 grp_g_o,
  output logic                 grp_p_o
);

  // Group generate: fold from the base bit upward, g[i] | p[i] & (lower G)
  always_comb begin
    grp_g_o = g_i[0];
    for (int i = 1; i < GROUPSIZE; i++) begin
      grp_g_o = g_i[i] | (p_i[i] & grp_g_o);
    end
  end

  assign grp_p_o = &p_i;

endmodule

`default_nettype wire

// File: rtl/group_gp_stage.sv
// ============================================================================
// Module : group_gp_stage
// Brief  : Registered valid/ready stage feeding the second-level prefix carry
//          tree. Produces bit p/g and packed group G/P with cin folded into
//          group 0. Define GP_SKID_EN to add one skid entry behind the out
//          register (registered in_ready, up to 2 beats held).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module group_gp_stage
  import group_gp_stage_pkg::*;
#(
  parameter int INPUTSIZE = DEF_INPUTSIZE,
  parameter int GROUPSIZE = DEF_GROUPSIZE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INPUTSIZE-1:0]                   a,
  input  logic [INPUTSIZE-1:0]                   b,
  input  logic                                   cin,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [2*(INPUTSIZE/GROUPSIZE)-1:0]     gp,
  output logic [INPUTSIZE-1:0]                   p_bit,
  output logic [INPUTSIZE-1:0]                   g_bit,
  output logic                                   cin_q
);

  localparam int TREESIZE = INPUTSIZE / GROUPSIZE;
  localparam int GPW      = 2 * TREESIZE;
  localparam int BEATW    = GPW + 2 * INPUTSIZE + 1;

  logic [INPUTSIZE-1:0] w_p;
  logic [INPUTSIZE-1:0] w_g;
  logic [GPW-1:0]       w_gp;
  logic [BEATW-1:0]     w_beat;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // One lookahead cell per group; cin only ever enters group 0
  for (genvar k = 0; k < TREESIZE; k++) begin : g_group
    logic w_grp_g;
    logic w_grp_p;

    group_pg #(.GROUPSIZE(GROUPSIZE)) u_pg (
      .p_i     (w_p[k*GROUPSIZE +: GROUPSIZE]),
      .g_i     (w_g[k*GROUPSIZE +: GROUPSIZE]),
      .grp_g_o (w_grp_g),
      .grp_p_o (w_grp_p)
    );

    assign w_gp[gp_pos(k, GP_P_IDX)] = w_grp_p;

    if (k == 0) begin : g_fold
      assign w_gp[gp_pos(k, GP_G_IDX)] = w_grp_g | (w_grp_p & cin);
    end else begin : g_plain
      assign w_gp[gp_pos(k, GP_G_IDX)] = w_grp_g;
    end
  end

  assign w_beat = {w_gp, w_p, w_g, cin};

  logic             out_valid_q;
  logic             out_valid_d;
  logic [BEATW-1:0] out_beat_q;
  logic [BEATW-1:0] w_out_beat_d;
  logic             w_load_out;
  logic             w_in_xfer;

`ifdef GP_SKID_EN
  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [BEATW-1:0] skid_beat_q;
  logic             w_load_skid;
  logic             w_sel_skid;
  logic             w_out_free;

  // in_ready is the registered "skid empty" flag, forced low while in reset
  assign in_ready   = ~rst & ~skid_valid_q;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_free = ~out_valid_q | out_ready;

  // Out slot refills from skid first (order), else from the input; a beat
  // arriving while out is stalled parks in skid
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    w_load_out   = 1'b0;
    w_load_skid  = 1'b0;
    w_sel_skid   = 1'b0;
    if (w_out_free) begin
      if (skid_valid_q) begin
        w_load_out   = 1'b1;
        w_sel_skid   = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        w_load_out  = w_in_xfer;
        out_valid_d = w_in_xfer;
      end
    end else if (w_in_xfer) begin
      w_load_skid  = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  assign w_out_beat_d = w_sel_skid ? skid_beat_q : w_beat;

  // Skid entry: emptied on reset so held data is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_beat_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (w_load_skid) begin
        skid_beat_q <= w_beat;
      end
    end
  end
`else
  // Single register: accept whenever the out slot is empty or draining
  assign in_ready     = ~rst & (~out_valid_q | out_ready);
  assign w_in_xfer    = in_valid & in_ready;
  assign w_load_out   = w_in_xfer;
  assign out_valid_d  = w_in_xfer | (out_valid_q & ~out_ready);
  assign w_out_beat_d = w_beat;
`endif

  // Out register: holds while stalled, new beat replaces a drained one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (w_load_out) begin
        out_beat_q <= w_out_beat_d;
      end
    end
  end

  assign out_valid                 = out_valid_q;
  assign {gp, p_bit, g_bit, cin_q} = out_beat_q;

endmodule

`default_nettype wire

// File: tb/tb_group_gp_stage.sv
`default_nettype none

module tb_group_gp_stage;

  typedef struct {
    logic [15:0] gp;
    logic [31:0] p;
    logic [31:0] g;
    logic        cin;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] gp;
  logic [31:0] p_bit;
  logic [31:0] g_bit;
  logic        cin_q;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t cur_exp;
  exp_t sb[$];
  int   out_cyc[$];

  logic [31:0] pool_a [12];
  logic [31:0] pool_b [12];
  logic        pool_c [12];

  group_gp_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gp        (gp),
    .p_bit     (p_bit),
    .g_bit     (g_bit),
    .cin_q     (cin_q)
  );

  always #5 clk = ~clk;

  // Reference: group G is the carry-out of the group add, P is all-propagate
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    exp_t       e;
    logic [4:0] s;
    logic [3:0] x;
    e.p   = ta ^ tb;
    e.g   = ta & tb;
    e.cin = tc;
    e.gp  = '0;
    for (int k = 0; k < 8; k++) begin
      s = {1'b0, ta[4*k +: 4]} + {1'b0, tb[4*k +: 4]} + ((k == 0) ? {4'b0, tc} : 5'd0);
      x = ta[4*k +: 4] ^ tb[4*k +: 4];
      e.gp[2*k+1] = s[4];
      e.gp[2*k]   = &x;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        exp_t e;
        n_chk++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: unexpected output gp=%h p=%h g=%h", gp, p_bit, g_bit);
        end else begin
          e = sb.pop_front();
          if (gp !== e.gp || p_bit !== e.p || g_bit !== e.g || cin_q !== e.cin) begin
            n_fail++;
            $display("FAIL out_beat: got gp=%h p=%h g=%h cin=%b expected gp=%h p=%h g=%h cin=%b",
                     gp, p_bit, g_bit, cin_q, e.gp, e.p, e.g, e.cin);
          end
        end
      end
    end
  end

  // Present one beat until accepted (bounded), then drop in_valid
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input exp_t e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    a = ta; b = tb; cin = tc; cur_exp = e; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // Offer pool beats with out stalled for ncyc cycles; report how many were taken
  task automatic stall_offer(input int ncyc, input int base, output int acc);
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      a = pool_a[base+acc]; b = pool_b[base+acc]; cin = pool_c[base+acc];
      cur_exp = model(a, b, cin);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   acc;
    int   exp_acc;
    int   k;

`ifdef GP_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif

    tbl[0] = '{32'h0000000F, 32'h00000001, 1'b0, '{16'h0002, 32'h0000000E, 32'h00000001, 1'b0}};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, '{16'h5557, 32'hFFFFFFFF, 32'h00000000, 1'b1}};
    tbl[2] = '{32'h00000000, 32'h00000000, 1'b1, '{16'h0000, 32'h00000000, 32'h00000000, 1'b1}};
    tbl[3] = '{32'h0000000F, 32'h00000000, 1'b1, '{16'h0003, 32'h0000000F, 32'h00000000, 1'b1}};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, '{16'h8000, 32'h00000000, 32'h80000000, 1'b0}};
    tbl[5] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 1'b1, '{16'h8888, 32'h00000000, 32'hF0F0F0F0, 1'b1}};

    for (int i = 0; i < 12; i++) begin
      pool_a[i] = $urandom;
      pool_b[i] = $urandom;
      pool_c[i] = 1'($urandom_range(0, 1));
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    cur_exp = '{16'h0, 32'h0, 32'h0, 1'b0};

    // Reset state
    idle(2);
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_gp", 64'(gp), 64'd0);
    chk("rst_p_bit", 64'(p_bit), 64'd0);
    chk("rst_g_bit", 64'(g_bit), 64'd0);
    chk("rst_cin_q", 64'(cin_q), 64'd0);
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Table vectors, one-cycle latency checked on each
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);
      @(negedge clk);
      chk("tbl_out_valid", 64'(out_valid), 64'd1);
      chk("tbl_gp", 64'(gp), 64'(tbl[i].e.gp));
      chk("tbl_p_bit", 64'(p_bit), 64'(tbl[i].e.p));
      chk("tbl_g_bit", 64'(g_bit), 64'(tbl[i].e.g));
      chk("tbl_cin_q", 64'(cin_q), 64'(tbl[i].e.cin));
      @(posedge clk); #1;
    end
    idle(2);

    // Back-pressure with three back-to-back beats
    out_cyc.delete();
    stall_offer(4, 0, acc);
    chk("stall_accepted", 64'(acc), 64'(exp_acc));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_gp_held", 64'(gp), 64'(sb[0].gp));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = acc; i < 3; i++) send(pool_a[i], pool_b[i], pool_c[i], model(pool_a[i], pool_b[i], pool_c[i]));
    idle(4);
    chk("stall_drained", 64'(sb.size()), 64'd0);
    chk("stall_out_count", 64'(out_cyc.size()), 64'd3);

    // Streaming throughput
    out_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc));
    end
    idle(3);
    chk("stream_count", 64'(out_cyc.size()), 64'd16);
    if (out_cyc.size() == 16) begin
      k = out_cyc[15] - out_cyc[0];
      chk("stream_consecutive", 64'(k), 64'd15);
    end

    // Reset while beats are held under back-pressure
    stall_offer(3, 3, acc);
    chk("rst_hold_accepted", 64'(acc), 64'(exp_acc));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_gp", 64'(gp), 64'd0);
    chk("rst_mid_p_bit", 64'(p_bit), 64'd0);
    chk("rst_mid_g_bit", 64'(g_bit), 64'd0);
    chk("rst_mid_cin_q", 64'(cin_q), 64'd0);
    chk("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_cyc.delete();
    out_ready = 1'b1;
    idle(4);
    chk("rst_held_never_appear", 64'(out_cyc.size()), 64'd0);

`ifdef GP_SKID_EN
    // Out and skid full; single out_ready pulse with in_valid high
    stall_offer(3, 6, acc);
    chk("skid_full_accepted", 64'(acc), 64'd2);
    a = pool_a[8]; b = pool_b[8]; cin = pool_c[8];
    cur_exp = model(a, b, cin);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pulse_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pulse_out_valid", 64'(out_valid), 64'd1);
    chk("pulse_gp_from_skid", 64'(gp), 64'(model(pool_a[7], pool_b[7], pool_c[7]).gp));
    chk("pulse_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("pulse_drained", 64'(sb.size()), 64'd0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
